// File: rtl/iter_divider.sv
// iter_divider -- multi-cycle restoring radix-2 integer divider.
//
// Produces one quotient bit per clock. Signed operands are reduced to
// magnitudes on acceptance. The signs are re-applied on the edge that enters
// DONE, so the results are registered.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   div_begin              request level, sampled only in IDLE
//   div_sign               1 = signed divide, 0 = unsigned
//   div_op1, div_op2       dividend, divisor
//   div_cancel             (DIV_CANCEL_EN only) flush: abandon the operation
//   div_result             quotient (all ones on a zero divisor)
//   div_remainder          remainder (dividend on a zero divisor)
//   div_end                one-cycle completion pulse (DONE state)
//   div_busy               high in BUSY and DONE
//
// Optional feature macro: DIV_CANCEL_EN adds the div_cancel input.
//
// Latency: div_begin accepted at the end of cycle T gives div_end in T+WIDTH+1.

module iter_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             div_begin,
   input  logic             div_sign,
   input  logic [WIDTH-1:0] div_op1,
   input  logic [WIDTH-1:0] div_op2,
`ifdef DIV_CANCEL_EN
   input  logic             div_cancel,
`endif
   output logic [WIDTH-1:0] div_result,
   output logic [WIDTH-1:0] div_remainder,
   output logic             div_end,
   output logic             div_busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd;       // dividend magnitude; quotient bits shift in at the LSB
   logic [WIDTH-1:0] dvs;       // divisor magnitude
   logic [WIDTH-1:0] rem;       // partial remainder
   logic [WIDTH-1:0] op1_raw;   // dividend as presented, returned on a zero divisor
   logic             a_neg;     // signed divide with a negative dividend
   logic             b_neg;     // signed divide with a negative divisor
   logic             dvs_zero;

   logic cancel;
`ifdef DIV_CANCEL_EN
   assign cancel = div_cancel;
`else
   assign cancel = 1'b0;
`endif

   // Operand conditioning. div_sign is folded into the sign flags, so an
   // unsigned divide never triggers a fix-up.
   logic             op1_neg, op2_neg;
   logic [WIDTH-1:0] op1_abs, op2_abs;

   assign op1_neg = div_sign & div_op1[WIDTH-1];
   assign op2_neg = div_sign & div_op2[WIDTH-1];
   assign op1_abs = op1_neg ? -div_op1 : div_op1;
   assign op2_abs = op2_neg ? -div_op2 : div_op2;

   // One restoring step. rem_shift carries an extra MSB so that a partial
   // remainder with its top bit set still compares correctly against the
   // divisor. When qbit is 1 the difference fits in WIDTH bits, so the
   // modulo-2^WIDTH subtraction is exact.
   logic [WIDTH:0]   rem_shift;
   logic             qbit;
   logic [WIDTH-1:0] rem_nxt, quo_nxt;

   assign rem_shift = {rem, dvd[WIDTH-1]};
   assign qbit      = (rem_shift >= {1'b0, dvs});
   assign rem_nxt   = qbit ? (rem_shift[WIDTH-1:0] - dvs) : rem_shift[WIDTH-1:0];
   assign quo_nxt   = {dvd[WIDTH-2:0], qbit};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         cnt           <= '0;
         dvd           <= '0;
         dvs           <= '0;
         rem           <= '0;
         op1_raw       <= '0;
         a_neg         <= 1'b0;
         b_neg         <= 1'b0;
         dvs_zero      <= 1'b0;
         div_result    <= '0;
         div_remainder <= '0;
         div_end       <= 1'b0;
         div_busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (div_begin && !cancel) begin
                  dvd      <= op1_abs;
                  dvs      <= op2_abs;
                  op1_raw  <= div_op1;
                  a_neg    <= op1_neg;
                  b_neg    <= op2_neg;
                  dvs_zero <= (div_op2 == '0);
                  rem      <= '0;
                  cnt      <= '0;
                  div_busy <= 1'b1;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (cancel) begin
                  div_busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  rem <= rem_nxt;
                  dvd <= quo_nxt;
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(WIDTH-1)) begin
                     // The final step and the sign fix-up share this edge.
                     if (dvs_zero) begin
                        div_result    <= '1;
                        div_remainder <= op1_raw;
                     end else begin
                        div_result    <= (a_neg ^ b_neg) ? -quo_nxt : quo_nxt;
                        div_remainder <= a_neg ? -rem_nxt : rem_nxt;
                     end
                     div_end <= 1'b1;
                     state   <= DONE;
                  end
               end
            end
            DONE: begin
               div_end  <= 1'b0;
               div_busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               div_end  <= 1'b0;
               div_busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iter_divider.sv
// Directed testbench for iter_divider (WIDTH = 32). Inputs are driven and
// outputs are sampled on the falling clock edge. Cycle k counts the rising
// edges after the one that accepted the request.

module tb_iter_divider;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        div_begin = 1'b0;
   logic        div_sign = 1'b0;
   logic [31:0] div_op1 = '0;
   logic [31:0] div_op2 = '0;
`ifdef DIV_CANCEL_EN
   logic        div_cancel = 1'b0;
`endif
   logic [31:0] div_result, div_remainder;
   logic        div_end, div_busy;

   int cmp_n = 0;
   int err_n = 0;

   iter_divider #(.WIDTH(32)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .div_begin     (div_begin),
      .div_sign      (div_sign),
      .div_op1       (div_op1),
      .div_op2       (div_op2),
`ifdef DIV_CANCEL_EN
      .div_cancel    (div_cancel),
`endif
      .div_result    (div_result),
      .div_remainder (div_remainder),
      .div_end       (div_end),
      .div_busy      (div_busy)
   );

   always #5 clk = ~clk;

   // Issue one request and observe 40 cycles. Reports the first div_end
   // cycle, the number of div_end cycles, the number of cycles where busy
   // was wrong, and the results captured in the first div_end cycle.
   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int end_cyc, output int end_cnt, output int busy_bad,
                         output logic [31:0] q, output logic [31:0] r);
      end_cyc = -1; end_cnt = 0; busy_bad = 0; q = '0; r = '0;
      @(negedge clk);
      div_sign = s; div_op1 = a; div_op2 = b; div_begin = 1'b1;
      @(negedge clk);
      div_begin = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (div_end) begin
            end_cnt++;
            if (end_cyc < 0) begin
               end_cyc = k; q = div_result; r = div_remainder;
            end
         end
         if (div_busy !== (k <= 33)) busy_bad++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #1;
      cmp_n++; if (div_result !== 32'h0) begin err_n++; $display("FAIL reset_q got %h want 0", div_result); end
      cmp_n++; if (div_remainder !== 32'h0) begin err_n++; $display("FAIL reset_r got %h want 0", div_remainder); end
      cmp_n++; if (div_end !== 1'b0) begin err_n++; $display("FAIL reset_end got %b want 0", div_end); end
      cmp_n++; if (div_busy !== 1'b0) begin err_n++; $display("FAIL reset_busy got %b want 0", div_busy); end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_unsigned_basic();
      int ec, en, bb; logic [31:0] q, r;
      run_op(1'b0, 32'd100, 32'd7, ec, en, bb, q, r);
      cmp_n++; if (q !== 32'd14) begin err_n++; $display("FAIL u100_7_q got %0d want 14", q); end
      cmp_n++; if (r !== 32'd2) begin err_n++; $display("FAIL u100_7_r got %0d want 2", r); end
      cmp_n++; if (ec !== 33) begin err_n++; $display("FAIL u100_7_end_cycle got %0d want 33", ec); end
      cmp_n++; if (en !== 1) begin err_n++; $display("FAIL u100_7_end_count got %0d want 1", en); end
      cmp_n++; if (bb !== 0) begin err_n++; $display("FAIL u100_7_busy_bad_cycles got %0d want 0", bb); end
   endtask

   task automatic test_signed();
      int ec, en, bb; logic [31:0] q, r;
      run_op(1'b1, 32'hFFFFFFF9, 32'h2, ec, en, bb, q, r);
      cmp_n++; if (q !== 32'hFFFFFFFD) begin err_n++; $display("FAIL s_m7_2_q got %h want fffffffd", q); end
      cmp_n++; if (r !== 32'hFFFFFFFF) begin err_n++; $display("FAIL s_m7_2_r got %h want ffffffff", r); end
      run_op(1'b0, 32'hFFFFFFF9, 32'h2, ec, en, bb, q, r);
      cmp_n++; if (q !== 32'h7FFFFFFC) begin err_n++; $display("FAIL u_fff9_2_q got %h want 7ffffffc", q); end
      cmp_n++; if (r !== 32'h1) begin err_n++; $display("FAIL u_fff9_2_r got %h want 1", r); end
      run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, ec, en, bb, q, r);
      cmp_n++; if (q !== 32'h80000000) begin err_n++; $display("FAIL s_ovf_q got %h want 80000000", q); end
      cmp_n++; if (r !== 32'h0) begin err_n++; $display("FAIL s_ovf_r got %h want 0", r); end
      run_op(1'b1, 32'd7, 32'hFFFFFFFE, ec, en, bb, q, r);
      cmp_n++; if (q !== 32'hFFFFFFFD) begin err_n++; $display("FAIL s_7_m2_q got %h want fffffffd", q); end
      cmp_n++; if (r !== 32'h1) begin err_n++; $display("FAIL s_7_m2_r got %h want 1", r); end
   endtask

   task automatic test_div_zero();
      int ec, en, bb; logic [31:0] q, r;
      for (int s = 0; s < 2; s++) begin
         run_op(s[0], 32'h12345678, 32'h0, ec, en, bb, q, r);
         cmp_n++; if (q !== 32'hFFFFFFFF) begin err_n++; $display("FAIL div0_q sign=%0d got %h want ffffffff", s, q); end
         cmp_n++; if (r !== 32'h12345678) begin err_n++; $display("FAIL div0_r sign=%0d got %h want 12345678", s, r); end
         cmp_n++; if (ec !== 33) begin err_n++; $display("FAIL div0_end_cycle sign=%0d got %0d want 33", s, ec); end
      end
   endtask

   task automatic test_back_to_back();
      int e1 = -1, e2 = -1, en = 0;
      logic [31:0] q1 = '0, r1 = '0, q2 = '0, r2 = '0;
      @(negedge clk);
      div_sign = 1'b0; div_op1 = 32'd100; div_op2 = 32'd7; div_begin = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 70; k++) begin
         if (k == 5) begin div_op1 = 32'd9; div_op2 = 32'd3; div_sign = 1'b1; end
         if (div_end) begin
            en++;
            if (e1 < 0) begin e1 = k; q1 = div_result; r1 = div_remainder; end
            else if (e2 < 0) begin e2 = k; q2 = div_result; r2 = div_remainder; end
         end
         @(negedge clk);
      end
      div_begin = 1'b0;
      cmp_n++; if (q1 !== 32'd14) begin err_n++; $display("FAIL b2b_first_q got %0d want 14", q1); end
      cmp_n++; if (r1 !== 32'd2) begin err_n++; $display("FAIL b2b_first_r got %0d want 2", r1); end
      cmp_n++; if (e1 !== 33) begin err_n++; $display("FAIL b2b_first_end got %0d want 33", e1); end
      cmp_n++; if (q2 !== 32'd3) begin err_n++; $display("FAIL b2b_second_q got %0d want 3", q2); end
      cmp_n++; if (r2 !== 32'd0) begin err_n++; $display("FAIL b2b_second_r got %0d want 0", r2); end
      cmp_n++; if (e2 !== 67) begin err_n++; $display("FAIL b2b_second_end got %0d want 67", e2); end
      cmp_n++; if (en !== 2) begin err_n++; $display("FAIL b2b_end_count got %0d want 2", en); end
      // A third request was accepted at cycle 68; clear it before moving on.
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset_mid();
      int en = 0; int ec, bb; logic [31:0] q, r;
      run_op(1'b0, 32'd100, 32'd7, ec, en, bb, q, r);  // leaves 14/2 on the outputs
      en = 0;
      @(negedge clk);
      div_sign = 1'b0; div_op1 = 32'd50; div_op2 = 32'd5; div_begin = 1'b1;
      @(negedge clk);
      div_begin = 1'b0;
      for (int k = 1; k < 10; k++) @(negedge clk);
      resetn = 1'b0;
      #1;
      cmp_n++; if (div_result !== 32'h0) begin err_n++; $display("FAIL rstmid_q got %h want 0", div_result); end
      cmp_n++; if (div_remainder !== 32'h0) begin err_n++; $display("FAIL rstmid_r got %h want 0", div_remainder); end
      cmp_n++; if (div_busy !== 1'b0) begin err_n++; $display("FAIL rstmid_busy got %b want 0", div_busy); end
      cmp_n++; if (div_end !== 1'b0) begin err_n++; $display("FAIL rstmid_end got %b want 0", div_end); end
      @(negedge clk);
      resetn = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (div_end) en++;
         @(negedge clk);
      end
      cmp_n++; if (en !== 0) begin err_n++; $display("FAIL rstmid_no_end got %0d want 0", en); end
   endtask

`ifdef DIV_CANCEL_EN
   task automatic test_cancel();
      int en = 0, ec = -1; int e0, n0, bb;
      logic [31:0] q = '0, r = '0, q0, r0;
      logic [31:0] q6 = '0, r6 = '0;
      run_op(1'b0, 32'd100, 32'd7, e0, n0, bb, q0, r0);  // prior result 14/2
      @(negedge clk);
      div_sign = 1'b1; div_op1 = 32'hFFFFFFF9; div_op2 = 32'h2; div_begin = 1'b1;
      @(negedge clk);
      div_begin = 1'b0;
      for (int k = 1; k <= 45; k++) begin
         if (k == 5) div_cancel = 1'b1;
         if (k == 6) begin div_cancel = 1'b0; q6 = div_result; r6 = div_remainder; end
         if (k == 7) div_begin = 1'b1;
         if (k == 8) div_begin = 1'b0;
         if (div_end) begin
            en++;
            if (ec < 0) begin ec = k; q = div_result; r = div_remainder; end
         end
         @(negedge clk);
      end
      cmp_n++; if (q6 !== 32'd14) begin err_n++; $display("FAIL cancel_keep_q got %0d want 14", q6); end
      cmp_n++; if (r6 !== 32'd2) begin err_n++; $display("FAIL cancel_keep_r got %0d want 2", r6); end
      cmp_n++; if (ec !== 40) begin err_n++; $display("FAIL cancel_end_cycle got %0d want 40", ec); end
      cmp_n++; if (en !== 1) begin err_n++; $display("FAIL cancel_end_count got %0d want 1", en); end
      cmp_n++; if (q !== 32'hFFFFFFFD) begin err_n++; $display("FAIL cancel_new_q got %h want fffffffd", q); end
      cmp_n++; if (r !== 32'hFFFFFFFF) begin err_n++; $display("FAIL cancel_new_r got %h want ffffffff", r); end
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_unsigned_basic();
      test_signed();
      test_div_zero();
      test_back_to_back();
      test_reset_mid();
`ifdef DIV_CANCEL_EN
      test_cancel();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule
